// File: rtl/arm_pkg.sv
// Shared types and constants for the multicycle ARM controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package arm_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_ADC = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ADC = 4'b0101;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // NZCV bit positions inside the 4-bit flag word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition-code evaluation; the 1111 encoding never executes
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, r;
    n  = f[FLAG_N];
    z  = f[FLAG_Z];
    cf = f[FLAG_C];
    v  = f[FLAG_V];
    case (c)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = cf;
      COND_CC: r = ~cf;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = cf & ~z;
      COND_LS: r = ~cf | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register, condition evaluation and gating of architectural writes.
// Latency: gating is combinational; flags update on the edge ending an EXEC cycle.
// Backpressure: none; write requests are either passed or suppressed.
module cond_unit
  import arm_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       use_saved_i,
  input  logic       pc_req_i,
  input  logic       reg_req_i,
  input  logic       mem_req_i,
  output logic       pc_en_o,
  output logic       reg_en_o,
  output logic       mem_en_o,
  output logic       carry_o
);

  logic [3:0] flags_q, flags_d;
  logic       saved_q, saved_d;
  logic       cond_ex, cond_use;

  assign cond_ex = cond_eval(cond_i, flags_q);

  // A flag-setting EXEC updates flags before ALU_WB; the writeback must still
  // use the verdict taken with the flags the instruction started with.
  assign saved_d  = cond_ex;
  assign cond_use = use_saved_i ? saved_q : cond_ex;

  // Flag next-state: NZ and CV halves written independently, only if executed
  always_comb begin
    flags_d = flags_q;
    if (cond_ex) begin
      if (flag_w_i[1]) flags_d[FLAG_N:FLAG_Z] = alu_flags_i[FLAG_N:FLAG_Z];
      if (flag_w_i[0]) flags_d[FLAG_C:FLAG_V] = alu_flags_i[FLAG_C:FLAG_V];
    end
  end

  // Flag and saved-condition registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      flags_q <= 4'b0000;
      saved_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  assign pc_en_o  = pc_req_i  & cond_use;
  assign reg_en_o = reg_req_i & cond_use;
  assign mem_en_o = mem_req_i & cond_use;
  assign carry_o  = flags_q[FLAG_C];

endmodule

// File: rtl/multicycle_controller.sv
// Main sequencing FSM and ALU decode for the multicycle ARM datapath.
// Latency: 3-5 cycles per instruction; outputs are combinational from state.
// Backpressure: none; one state per clock, memory assumed single-cycle.
module multicycle_controller
  import arm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         op,
  input  logic [5:0]         funct,
  input  logic [3:0]         rd,
  input  logic [3:0]         cond,
  input  logic [3:0]         alu_flags,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic [1:0]         result_src,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [1:0]         reg_src,
  output logic [2:0]         alu_ctl,
  output logic               shift,
  output logic               carry,
  output logic [STATE_W-1:0] state
);

  state_t     state_q, state_d;
  logic [3:0] cmd;
  logic       is_cmp, s_eff, cv_op;
  logic [2:0] ctl_dec;
  logic       mov_dec;
  logic       fetch_pc, irw, pc_req, reg_req, mem_req, in_exec, use_saved;
  logic [1:0] flag_w;
  logic       pc_en, reg_en, mem_en;

  assign cmd    = funct[4:1];
  assign is_cmp = (cmd == CMD_CMP);
  assign s_eff  = funct[0] | is_cmp;
  assign cv_op  = (cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_ADC) | is_cmp;
  assign flag_w = in_exec ? {s_eff, s_eff & cv_op} : 2'b00;

  // ALU operation decode from the data-processing cmd field
  always_comb begin
    ctl_dec = ALU_ADD;
    mov_dec = 1'b0;
    case (cmd)
      CMD_ADD:          ctl_dec = ALU_ADD;
      CMD_SUB, CMD_CMP: ctl_dec = ALU_SUB;
      CMD_AND:          ctl_dec = ALU_AND;
      CMD_ORR:          ctl_dec = ALU_ORR;
      CMD_ADC:          ctl_dec = ALU_ADC;
      CMD_MOV:          mov_dec = 1'b1;
      default:          ctl_dec = ALU_ADD;
    endcase
  end

  // State register; unused encodings fall back to FETCH via the default arm
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = S_FETCH;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    shift      = 1'b0;
    irw        = 1'b0;
    fetch_pc   = 1'b0;
    pc_req     = 1'b0;
    reg_req    = 1'b0;
    mem_req    = 1'b0;
    in_exec    = 1'b0;
    use_saved  = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        irw        = 1'b1;
        fetch_pc   = 1'b1;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXEC_I : S_EXEC_R;
          2'b01:   state_d = S_MEM_ADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_req    = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
        alu_ctl   = ctl_dec;
        shift     = mov_dec;
        in_exec   = 1'b1;
        state_d   = is_cmp ? S_FETCH : S_ALU_WB;
      end
      S_ALU_WB: begin
        use_saved = 1'b1;
        if (rd == 4'd15) pc_req  = 1'b1;
        else             reg_req = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_req     = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  cond_unit u_cond (
    .clk_i       (clk),
    .reset_i     (reset),
    .cond_i      (cond),
    .alu_flags_i (alu_flags),
    .flag_w_i    (flag_w),
    .use_saved_i (use_saved),
    .pc_req_i    (pc_req),
    .reg_req_i   (reg_req),
    .mem_req_i   (mem_req),
    .pc_en_o     (pc_en),
    .reg_en_o    (reg_en),
    .mem_en_o    (mem_en),
    .carry_o     (carry)
  );

  // Reset suppresses every architectural write so an aborted instruction leaves no trace
  assign pc_write  = ~reset & (fetch_pc | pc_en);
  assign ir_write  = ~reset & irw;
  assign reg_write = ~reset & reg_en;
  assign mem_write = ~reset & mem_en;

  assign imm_src = op;
  assign reg_src = {op == 2'b01, op == 2'b10};
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cond, alu_flags;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_b, imm_src, reg_src;
  logic       alu_src_a, shift, carry;
  logic [2:0] alu_ctl;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd), .cond(cond),
    .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl), .shift(shift),
    .carry(carry), .state(state)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference NZCV flags and per-instruction observations
  logic [3:0] m_flags;
  int n_pcw, n_rgw, n_mw, obs_ctl, obs_sh, obs_seq;

  typedef struct {
    logic [3:0] cmd;
    logic [2:0] ctl;
    logic       sh;
  } dec_vec_t;
  dec_vec_t tv[8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ARM condition table written out from the architecture
  function automatic bit holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] dec_ctl(input logic [3:0] c);
    case (c)
      4'b0010, 4'b1010: return 3'd1;
      4'b0000:          return 3'd2;
      4'b1100:          return 3'd3;
      4'b0101:          return 3'd4;
      default:          return 3'd0;
    endcase
  endfunction

  // expected control word for one state of an instruction whose verdict is ex
  function automatic logic [13:0] exp_out(input int s, input bit ex, input logic [3:0] r,
                                          input logic [3:0] c);
    logic pcw, irw, rgw, mw, adr, asa, sh;
    logic [1:0] rs, asb;
    logic [2:0] ctl;
    pcw = (s == 0) || (s == 9 && ex) || (s == 8 && r == 4'd15 && ex);
    irw = (s == 0);
    rgw = (s == 4 && ex) || (s == 8 && r != 4'd15 && ex);
    mw  = (s == 5 && ex);
    adr = (s == 3 || s == 5);
    rs  = (s == 0 || s == 1 || s == 9) ? 2'd2 : (s == 4) ? 2'd1 : 2'd0;
    asa = (s == 0 || s == 1);
    asb = (s == 0 || s == 1) ? 2'd2 : (s == 2 || s == 7 || s == 9) ? 2'd1 : 2'd0;
    ctl = (s == 6 || s == 7) ? dec_ctl(c) : 3'd0;
    sh  = (s == 6 || s == 7) && c == 4'b1101;
    return {pcw, irw, rgw, mw, adr, rs, asa, asb, ctl, sh};
  endfunction

  // Runs one instruction from FETCH, checking every cycle against the model
  task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] r,
                           input logic [3:0] c, input logic [3:0] af);
    int path[$];
    bit ex, s_eff;
    logic [3:0] cv;
    logic [13:0] obs;
    cv = f[4:1];
    ex = holds(c, m_flags);
    path = {0, 1};
    case (o)
      2'd0: begin
        path.push_back(f[5] ? 7 : 6);
        if (cv != 4'b1010) path.push_back(8);
      end
      2'd1: begin
        path.push_back(2);
        if (f[0]) begin path.push_back(3); path.push_back(4); end
        else path.push_back(5);
      end
      2'd2: path.push_back(9);
      default: ;
    endcase
    op = o; funct = f; rd = r; cond = c; alu_flags = af;
    n_pcw = 0; n_rgw = 0; n_mw = 0; obs_ctl = -1; obs_sh = -1; obs_seq = 0;
    foreach (path[i]) begin
      #1;
      obs_seq = (obs_seq << 4) | int'(state);
      check("state", int'(state), path[i]);
      obs = {pc_write, ir_write, reg_write, mem_write, adr_src, result_src,
             alu_src_a, alu_src_b, alu_ctl, shift};
      check("ctl_word", int'(obs), int'(exp_out(path[i], ex, r, cv)));
      if (pc_write)  n_pcw++;
      if (reg_write) n_rgw++;
      if (mem_write) n_mw++;
      if (path[i] == 6 || path[i] == 7) begin
        obs_ctl = int'(alu_ctl);
        obs_sh  = int'(shift);
      end
      @(negedge clk);
    end
    check("imm_src", int'(imm_src), int'(o));
    check("reg_src", int'(reg_src), int'({o == 2'd1, o == 2'd2}));
    if (o == 2'd0 && ex) begin
      s_eff = f[0] || cv == 4'b1010;
      if (s_eff) begin
        m_flags[3:2] = af[3:2];
        if (cv inside {4'b0100, 4'b0010, 4'b0101, 4'b1010}) m_flags[1:0] = af[1:0];
      end
    end
    check("carry", int'(carry), int'(m_flags[1]));
  endtask

  initial begin
    tv[0] = '{4'b0100, 3'b000, 1'b0};
    tv[1] = '{4'b0010, 3'b001, 1'b0};
    tv[2] = '{4'b1010, 3'b001, 1'b0};
    tv[3] = '{4'b0000, 3'b010, 1'b0};
    tv[4] = '{4'b1100, 3'b011, 1'b0};
    tv[5] = '{4'b0101, 3'b100, 1'b0};
    tv[6] = '{4'b1101, 3'b000, 1'b1};
    tv[7] = '{4'b0001, 3'b000, 1'b0};

    reset = 1'b1; op = 2'b00; funct = 6'd0; rd = 4'd0; cond = 4'hE; alu_flags = 4'd0;
    m_flags = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", int'(state), 0);
    check("rst_pc_write", int'(pc_write), 0);
    check("rst_ir_write", int'(ir_write), 0);
    check("rst_reg_write", int'(reg_write), 0);
    check("rst_mem_write", int'(mem_write), 0);
    check("rst_carry", int'(carry), 0);
    reset = 1'b0;

    // AND r0 right after reset
    run_instr(2'b00, 6'b000000, 4'd0, 4'hE, 4'd0);
    check("and_seq", obs_seq, 'h0168);
    check("and_pcw_cnt", n_pcw, 1);
    check("and_rgw_cnt", n_rgw, 1);

    // LDR
    run_instr(2'b01, 6'b011001, 4'd2, 4'hE, 4'd0);
    check("ldr_seq", obs_seq, 'h01234);
    check("ldr_rgw_cnt", n_rgw, 1);

    // STREQ with Z clear: no store
    run_instr(2'b01, 6'b011000, 4'd3, 4'h0, 4'd0);
    check("streq_seq", obs_seq, 'h0125);
    check("streq_mw_cnt", n_mw, 0);

    // CMP then ADC consuming the stored carry
    run_instr(2'b00, 6'b010101, 4'd0, 4'hE, 4'b0110);
    check("cmp_seq", obs_seq, 'h016);
    check("cmp_carry", int'(carry), 1);
    run_instr(2'b00, 6'b001010, 4'd1, 4'hE, 4'd0);
    check("adc_ctl", obs_ctl, 4);
    check("adc_carry", int'(carry), 1);

    // B always, then BNE with Z set
    run_instr(2'b10, 6'b000000, 4'd0, 4'hE, 4'd0);
    check("b_seq", obs_seq, 'h019);
    check("b_pcw_cnt", n_pcw, 2);
    run_instr(2'b10, 6'b000000, 4'd0, 4'h1, 4'd0);
    check("bne_pcw_cnt", n_pcw, 1);

    // ALU decode table
    for (int i = 0; i < 8; i++) begin
      run_instr(2'b00, {1'b0, tv[i].cmd, 1'b0}, 4'd1, 4'hE, 4'd0);
      check($sformatf("dec_ctl_%0d", i), obs_ctl, int'(tv[i].ctl));
      check($sformatf("dec_sh_%0d", i), obs_sh, int'(tv[i].sh));
    end

    // Reset arriving during MEM_ADR of a store
    run_instr(2'b00, 6'b010101, 4'd0, 4'hE, 4'b0010);
    op = 2'b01; funct = 6'b011000; rd = 4'd4; cond = 4'hE;
    @(negedge clk); @(negedge clk);
    #1;
    check("abort_in_memadr", int'(state), 2);
    reset = 1'b1;
    #1;
    check("abort_mem_write", int'(mem_write), 0);
    check("abort_reg_write", int'(reg_write), 0);
    check("abort_pc_write", int'(pc_write), 0);
    @(negedge clk);
    #1;
    check("abort_state", int'(state), 0);
    check("abort_carry", int'(carry), 0);
    check("abort_mem_write2", int'(mem_write), 0);
    check("abort_ir_write", int'(ir_write), 0);
    reset = 1'b0;
    m_flags = 4'd0;

    // randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      run_instr(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom));
    end
    #1;
    check("final_state", int'(state), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
